// File: rtl/motor_ramp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : motor_ramp_scheduler
//  Purpose  : Accepts per-motor speed/direction targets and ramps four
//             motors toward them at a fixed rate. A direction change is
//             applied only once the motor has reached speed 0. The four
//             motors share one write port into motor_controller; this block
//             drives that port one motor at a time. A command watchdog
//             forces every target to 0 if the host stops sending commands.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             cmd_valid/cmd_ready - command handshake
//             cmd_motor/cmd_direction/cmd_speed - command payload
//             motor_select/speed/direction - time-multiplexed output port
//             moving              - per-motor "current speed != 0"
//             wd_expired          - safety stop active
//  Revision : 1.0 - initial release
// ============================================================================
module motor_ramp_scheduler #(
    parameter int TickDiv       = 100000,
    parameter int RampStep      = 1,
    parameter int MaxSpeed      = 28,
    parameter int WatchdogTicks = 500,
    parameter int SlotCycles    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_motor,
    input  logic       cmd_direction,
    input  logic [4:0] cmd_speed,
    output logic [1:0] motor_select,
    output logic [4:0] speed,
    output logic       direction,
    output logic [3:0] moving,
    output logic       wd_expired
);

    localparam int TICK_W = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int WD_W   = $clog2(WatchdogTicks + 1);
    localparam int SLOT_W = $clog2(SlotCycles);

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TickDiv - 1);
    localparam logic [WD_W-1:0]   C_WD_MAX    = WD_W'(WatchdogTicks);
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SlotCycles - 1);
    localparam logic [5:0]        C_STEP6     = 6'(RampStep);
    localparam logic [4:0]        C_MAX_SPD   = 5'(MaxSpeed);

    // One ramp step for one motor; returns {next_dir, next_speed}.
    // All arithmetic is done 6 bits wide so cur+step cannot wrap.
    function automatic logic [5:0] ramp_next(
        input logic [4:0] cur,
        input logic [4:0] tgt,
        input logic       cdir,
        input logic       tdir
    );
        logic [5:0] cur6;
        logic [5:0] tgt6;
        logic [5:0] up6;
        logic [4:0] nspd;
        logic       ndir;
        cur6 = {1'b0, cur};
        tgt6 = {1'b0, tgt};
        up6  = cur6 + C_STEP6;
        nspd = cur;
        ndir = cdir;
        if (cdir != tdir) begin
            // Brake to zero first; flip direction only while stopped.
            if (cur != 5'd0) begin
                nspd = (cur6 > C_STEP6) ? 5'(cur6 - C_STEP6) : 5'd0;
            end else begin
                ndir = tdir;
            end
        end else if (cur6 < tgt6) begin
            nspd = (up6 > tgt6) ? tgt : up6[4:0];
        end else if (cur6 > tgt6) begin
            nspd = (cur6 > (tgt6 + C_STEP6)) ? 5'(cur6 - C_STEP6) : tgt;
        end
        return {ndir, nspd};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q,   wd_cnt_d;
    logic [3:0][4:0]   tgt_speed_q, tgt_speed_d;
    logic [3:0]        tgt_dir_q,   tgt_dir_d;
    logic [3:0][4:0]   cur_speed_q, cur_speed_d;
    logic [3:0]        cur_dir_q,   cur_dir_d;
    logic [SLOT_W-1:0] slot_cnt_q,  slot_cnt_d;
    logic [1:0]        mot_idx_q,   mot_idx_d;
    logic [1:0]        sel_q,       sel_d;
    logic [4:0]        spd_q,       spd_d;
    logic              dir_q,       dir_d;

    logic              w_tick;
    logic              w_accept;
    logic [4:0]        w_cmd_spd;
    logic [3:0][5:0]   w_ramp;

    assign cmd_ready  = ~reset;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_tick     = (tick_cnt_q == C_TICK_LAST);
    assign w_cmd_spd  = (cmd_speed > C_MAX_SPD) ? C_MAX_SPD : cmd_speed;
    assign wd_expired = (wd_cnt_q == C_WD_MAX);

    assign motor_select = sel_q;
    assign speed        = spd_q;
    assign direction    = dir_q;

    for (genvar m = 0; m < 4; m++) begin : g_motor
        assign w_ramp[m] = ramp_next(cur_speed_q[m], tgt_speed_q[m],
                                     cur_dir_q[m], tgt_dir_q[m]);
        assign moving[m] = |cur_speed_q[m];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tick_cnt_d  = w_tick ? '0 : tick_cnt_q + 1'b1;

        wd_cnt_d    = wd_cnt_q;
        if (w_accept) begin
            wd_cnt_d = '0;
        end else if (w_tick && !wd_expired) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        // Safety stop zeroes every target; an accepted command then
        // overrides its own motor's entry in the same cycle.
        tgt_speed_d = wd_expired ? '0 : tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        if (w_accept) begin
            tgt_speed_d[cmd_motor] = w_cmd_spd;
            tgt_dir_d[cmd_motor]   = cmd_direction;
        end

        cur_speed_d = cur_speed_q;
        cur_dir_d   = cur_dir_q;
        if (w_tick) begin
            for (int m = 0; m < 4; m++) begin
                cur_speed_d[m] = w_ramp[m][4:0];
                cur_dir_d[m]   = w_ramp[m][5];
            end
        end

        slot_cnt_d = (slot_cnt_q == C_SLOT_LAST) ? '0 : slot_cnt_q + 1'b1;
        mot_idx_d  = (slot_cnt_q == C_SLOT_LAST) ? mot_idx_q + 1'b1 : mot_idx_q;

        // Output port is loaded only at slot start and held for the slot,
        // so motor_controller always sees a consistent select/speed pair.
        sel_d = sel_q;
        spd_d = spd_q;
        dir_d = dir_q;
        if (slot_cnt_q == '0) begin
            sel_d = mot_idx_q;
            spd_d = cur_speed_q[mot_idx_q];
            dir_d = cur_dir_q[mot_idx_q];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            wd_cnt_q    <= '0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= '0;
            cur_speed_q <= '0;
            cur_dir_q   <= '0;
            slot_cnt_q  <= '0;
            mot_idx_q   <= '0;
            sel_q       <= '0;
            spd_q       <= '0;
            dir_q       <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            cur_speed_q <= cur_speed_d;
            cur_dir_q   <= cur_dir_d;
            slot_cnt_q  <= slot_cnt_d;
            mot_idx_q   <= mot_idx_d;
            sel_q       <= sel_d;
            spd_q       <= spd_d;
            dir_q       <= dir_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_ramp_scheduler
//  Purpose  : Directed self-checking bench for motor_ramp_scheduler with
//             TickDiv=10, RampStep=1, MaxSpeed=28, WatchdogTicks=8,
//             SlotCycles=4. Ramp ticks land on edges 10,20,... after reset
//             release; slot starts land on edges 1,5,9,... (motor
//             ((e-1)/4)%4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_motor;
    logic       cmd_direction;
    logic [4:0] cmd_speed;
    logic [1:0] motor_select;
    logic [4:0] speed;
    logic       direction;
    logic [3:0] moving;
    logic       wd_expired;

    int errors = 0;
    int checks = 0;
    int ecount = 0;   // rising edges since reset release

    motor_ramp_scheduler #(
        .TickDiv      (10),
        .RampStep     (1),
        .MaxSpeed     (28),
        .WatchdogTicks(8),
        .SlotCycles   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_motor    (cmd_motor),
        .cmd_direction(cmd_direction),
        .cmd_speed    (cmd_speed),
        .motor_select (motor_select),
        .speed        (speed),
        .direction    (direction),
        .moving       (moving),
        .wd_expired   (wd_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; leaves time 1 unit past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    task automatic next_tick();
        step(10 - (ecount % 10));
    endtask

    // Accept a command on an edge that is not a ramp tick.
    task automatic send(input logic [1:0] m, input logic d, input logic [4:0] s);
        if ((ecount % 10) == 9) step(1);
        cmd_motor = m; cmd_direction = d; cmd_speed = s; cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    // Accept a command exactly on a ramp-tick edge.
    task automatic send_on_tick(input logic [1:0] m, input logic d, input logic [4:0] s);
        int n;
        n = (19 - (ecount % 10)) % 10;
        if (n > 0) step(n);
        cmd_motor = m; cmd_direction = d; cmd_speed = s; cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_slot_start(input int m);
        for (int i = 0; i < 20; i++) begin
            if ((ecount % 4) == 1 && (((ecount - 1) / 4) % 4) == m) break;
            step(1);
        end
    endtask

    initial begin
        int exp_spd [7];
        int rev_spd [6];
        int rev_dir [6];
        int sel;
        exp_spd = '{0, 1, 2, 3, 4, 5, 5};
        rev_spd = '{2, 1, 0, 0, 1, 2};
        rev_dir = '{0, 0, 0, 1, 1, 1};

        // ---------------- reset state ----------------
        reset = 1'b1; cmd_valid = 1'b0; cmd_motor = '0;
        cmd_direction = 1'b0; cmd_speed = '0;
        step(3);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_motor_select", motor_select, 0);
        chk("rst_speed", speed, 0);
        chk("rst_direction", direction, 0);
        chk("rst_moving", moving, 0);
        chk("rst_wd_expired", wd_expired, 0);
        reset = 1'b0;
        ecount = 0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // ---------------- ramp up motor 1 to 5, dir 1 ----------------
        // Starting dir is 0, so the first tick only flips direction.
        send(2'd1, 1'b1, 5'd5);
        for (int k = 0; k < 7; k++) begin
            next_tick();
            chk("rampup_speed", dut.cur_speed_q[1], exp_spd[k]);
            chk("rampup_dir", dut.cur_dir_q[1], 1);
        end
        send(2'd1, 1'b1, 5'd5);
        chk("rampup_moving", moving, 4'b0010);

        // ---------------- scheduler rotation ----------------
        wait_slot_start(0);
        for (int i = 0; i < 20; i++) begin
            sel = ((ecount - 1) / 4) % 4;
            chk("rot_select", motor_select, sel);
            chk("rot_speed", speed, (sel == 1) ? 5 : 0);
            chk("rot_direction", direction, (sel == 1) ? 1 : 0);
            step(1);
        end

        // ---------------- clamp: motor 0 speed 31 -> 28 ----------------
        send(2'd0, 1'b0, 5'd31);
        for (int k = 1; k <= 30; k++) begin
            next_tick();
            chk("clamp_speed", dut.cur_speed_q[0], (k < 28) ? k : 28);
            send(2'd0, 1'b0, 5'd31);
        end
        chk("clamp_moving", moving, 4'b0011);
        wait_slot_start(0);
        chk("clamp_port_sel", motor_select, 0);
        chk("clamp_port_speed", speed, 28);
        chk("clamp_port_dir", direction, 0);

        // ---------------- reversal on motor 2 ----------------
        send(2'd2, 1'b0, 5'd3);
        for (int k = 1; k <= 3; k++) begin
            next_tick();
            chk("rev_pre_speed", dut.cur_speed_q[2], k);
            send(2'd2, 1'b0, 5'd3);
        end
        send(2'd2, 1'b1, 5'd2);
        for (int k = 0; k < 6; k++) begin
            next_tick();
            chk("rev_speed", dut.cur_speed_q[2], rev_spd[k]);
            chk("rev_dir", dut.cur_dir_q[2], rev_dir[k]);
            send(2'd2, 1'b1, 5'd2);
        end

        // ---------------- command collides with tick ----------------
        send_on_tick(2'd2, 1'b1, 5'd5);
        chk("collide_old_target", dut.cur_speed_q[2], 2);
        next_tick();
        chk("collide_new_target", dut.cur_speed_q[2], 3);

        // ---------------- watchdog on motor 3 ----------------
        send(2'd3, 1'b0, 5'd4);
        for (int k = 1; k <= 4; k++) begin
            next_tick();
            send(2'd3, 1'b0, 5'd4);
        end
        chk("wd_pre_speed", dut.cur_speed_q[3], 4);
        for (int t = 1; t <= 12; t++) begin
            next_tick();
            if (t == 7) chk("wd_not_yet", wd_expired, 0);
            if (t == 8) chk("wd_expired", wd_expired, 1);
            if (t >= 9) chk("wd_rampdown", dut.cur_speed_q[3], 12 - t);
        end
        chk("wd_still_expired", wd_expired, 1);
        send(2'd3, 1'b0, 5'd2);
        chk("wd_cleared", wd_expired, 0);
        next_tick();
        next_tick();
        chk("wd_reramp", dut.cur_speed_q[3], 2);

        // ---------------- reset mid-ramp ----------------
        send(2'd3, 1'b0, 5'd20);
        next_tick();
        next_tick();
        chk("pre_reset_speed", dut.cur_speed_q[3], 4);
        reset = 1'b1;
        step(1);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_select", motor_select, 0);
        chk("midrst_speed", speed, 0);
        chk("midrst_direction", direction, 0);
        chk("midrst_moving", moving, 0);
        chk("midrst_wd", wd_expired, 0);
        reset = 1'b0;
        step(2);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_moving", moving, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
